// File: rtl/spi_master_interface.sv
// SPI master for the 10-bit SPI RAM frame protocol. A parallel command goes out MSB-first on MOSI;
// read-data frames (opcode 11) return an 8-bit reply captured from MISO.
module spi_master_interface #(
    parameter int FRAME_WIDTH  = 10,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 3,
    parameter int IDLE_GAP     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [FRAME_WIDTH-1:0] cmd,
    output logic                   busy,
    output logic                   done,
    output logic                   rx_valid,
    output logic [DATA_WIDTH-1:0]  rx_data,
    output logic                   MOSI,
    input  logic                   MISO,
    output logic                   SS_n
);

    // state | meaning
    // IDLE  | SS_n high, waiting for start
    // CMD   | command-check bit (cmd MSB)
    // SHIFT | FRAME_WIDTH command bits, MSB first
    // WAIT  | slave read latency before the reply
    // RECV  | reply bits captured from MISO
    // HOLD  | one closing cycle with SS_n still low
    // GAP   | SS_n high, done/rx_valid pulse in the first cycle
    typedef enum logic [2:0] {IDLE, CMD, SHIFT, WAIT, RECV, HOLD, GAP} state_t;

    localparam int MAX_A  = (FRAME_WIDTH > DATA_WIDTH) ? FRAME_WIDTH : DATA_WIDTH;
    localparam int MAX_B  = (READ_LATENCY > IDLE_GAP) ? READ_LATENCY : IDLE_GAP;
    localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_WIDTH - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [FRAME_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0]  rxreg;
    logic                   is_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            rxreg    <= '0;
            is_read  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            MOSI     <= 1'b0;
            SS_n     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    SS_n     <= 1'b1;
                    MOSI     <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    rx_valid <= 1'b0;
                    if (start) begin
                        shreg   <= cmd;
                        is_read <= (cmd[FRAME_WIDTH-1 -: 2] == 2'b11);
                        busy    <= 1'b1;
                        SS_n    <= 1'b0;
                        MOSI    <= cmd[FRAME_WIDTH-1];
                        cnt     <= '0;
                        state   <= CMD;
                    end
                end
                CMD: begin
                    MOSI  <= shreg[FRAME_WIDTH-1];
                    shreg <= shreg << 1;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == SHIFT_LAST) begin
                        MOSI  <= 1'b0;
                        cnt   <= '0;
                        state <= is_read ? WAIT : HOLD;
                    end else begin
                        MOSI  <= shreg[FRAME_WIDTH-1];
                        shreg <= shreg << 1;
                        cnt   <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // The first reply bit is taken on the edge that leaves WAIT.
                    if (cnt == WAIT_LAST) begin
                        rxreg <= {rxreg[DATA_WIDTH-2:0], MISO};
                        cnt   <= '0;
                        state <= RECV;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RECV: begin
                    if (cnt == RECV_LAST) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else begin
                        rxreg <= {rxreg[DATA_WIDTH-2:0], MISO};
                        cnt   <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    SS_n     <= 1'b1;
                    done     <= 1'b1;
                    rx_valid <= is_read;
                    if (is_read) rx_data <= rxreg;
                    cnt      <= '0;
                    state    <= GAP;
                end
                GAP: begin
                    done     <= 1'b0;
                    rx_valid <= 1'b0;
                    if (cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_interface.sv
// Bench for spi_master_interface: frame-offset reference model with a small RAM slave,
// per-cycle output comparison and directed/random frame sequences.
module tb_spi_master_interface;

    localparam int FW    = 10;
    localparam int DW    = 8;
    localparam int RL    = 3;
    localparam int GAP   = 2;
    localparam int L_WR  = FW + 2;
    localparam int L_RD  = FW + 2 + RL + DW;
    localparam int S_LO  = FW + 1 + RL;
    localparam int S_HI  = S_LO + DW - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [FW-1:0] cmd = '0;
    logic          MISO = 1'b0;
    logic          busy, done, rx_valid, MOSI, SS_n;
    logic [DW-1:0] rx_data;

    spi_master_interface #(.FRAME_WIDTH(FW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .IDLE_GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .busy(busy), .done(done),
        .rx_valid(rx_valid), .rx_data(rx_data), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int done_cnt = 0;
    int rxv_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position of the current frame counted in edges since acceptance.
    bit            m_act = 1'b0;
    int            m_k = 0;
    logic [FW-1:0] m_cmd = '0;
    bit            m_rd = 1'b0;
    logic [DW-1:0] m_acc = '0;
    logic [DW-1:0] m_rx = '0;
    logic [7:0]    s_ram [256];
    logic [7:0]    s_addr = '0;
    logic [7:0]    s_word = '0;

    function automatic int flen(input bit rd);
        return rd ? L_RD : L_WR;
    endfunction

    initial for (int i = 0; i < 256; i++) s_ram[i] = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 1'b0;
            m_k   = 0;
            m_acc = '0;
            m_rx  = '0;
        end else if (!m_act) begin
            if (start) begin
                m_act  = 1'b1;
                m_k    = 0;
                m_cmd  = cmd;
                m_rd   = (cmd[9:8] == 2'b11);
                m_acc  = '0;
                s_word = s_ram[s_addr];
            end
        end else begin
            m_k++;
            if (m_rd && m_k >= S_LO && m_k <= S_HI) m_acc = {m_acc[DW-2:0], MISO};
            if (m_k == flen(m_rd)) begin
                if (m_rd) m_rx = m_acc;
                case (m_cmd[9:8])
                    2'b00:   s_addr = m_cmd[7:0];
                    2'b01:   s_ram[s_addr] = m_cmd[7:0];
                    2'b10:   s_addr = m_cmd[7:0];
                    default: ;
                endcase
            end
            if (m_k == flen(m_rd) + GAP) m_act = 1'b0;
        end
    end

    // Slave drives the reply during read-data frames; noise on MISO everywhere else.
    always @(negedge clk) begin
        int nk;
        nk = m_k + 1;
        if (m_act && m_rd && nk >= S_LO && nk <= S_HI) MISO = s_word[S_HI - nk];
        else MISO = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        logic e_ss, e_mosi, e_done;
        if (rst_n && chk_en) begin
            e_ss   = !(m_act && m_k < flen(m_rd));
            e_mosi = (m_act && m_k <= FW) ? ((m_k == 0) ? m_cmd[FW-1] : m_cmd[FW-m_k]) : 1'b0;
            e_done = m_act && (m_k == flen(m_rd));
            check("ss_n", SS_n, e_ss);
            check("mosi", MOSI, e_mosi);
            check("busy", busy, m_act);
            check("done", done, e_done);
            check("rx_valid", rx_valid, e_done && m_rd);
            check("rx_data", rx_data, m_rx);
            if (done) done_cnt++;
            if (rx_valid) rxv_cnt++;
        end
    end

    task automatic do_frame(input logic [FW-1:0] c, output int done_off, output int busy_off,
                            output int ss_low, output logic [FW:0] mseq);
        done_off = -1;
        busy_off = -1;
        ss_low   = 0;
        mseq     = '0;
        start = 1'b1;
        cmd   = c;
        @(posedge clk);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            cmd   = FW'($urandom);
            if (n <= FW) mseq = {mseq[FW-1:0], MOSI};
            if (!SS_n) ss_low++;
            if (done && done_off < 0) done_off = n;
            if (!busy) begin
                busy_off = n;
                break;
            end
        end
        if (busy_off < 0) check("frame_timeout", 1, 0);
    endtask

    initial begin
        int d_off, b_off, sl, rx0, dn0, hi_run, runs, hi_ok;
        logic [FW:0] ms;
        logic prev_ss;

        repeat (3) @(negedge clk);
        check("rst_ss_n", SS_n, 1);
        check("rst_mosi", MOSI, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        do_frame(10'h001, d_off, b_off, sl, ms);
        check("t1_mosi_seq", ms, 11'b000_0000_0001);
        check("t1_ss_low", sl, 12);
        check("t1_done_off", d_off, 12);
        check("t1_busy_off", b_off, 14);

        rx0 = rxv_cnt;
        do_frame(10'h001, d_off, b_off, sl, ms);
        do_frame(10'h10A, d_off, b_off, sl, ms);
        do_frame(10'h201, d_off, b_off, sl, ms);
        do_frame(10'h300, d_off, b_off, sl, ms);
        check("ram_rx_valid_cnt", rxv_cnt - rx0, 1);
        check("ram_rx_data", rx_data, 8'h0A);

        do_frame(10'h022, d_off, b_off, sl, ms);
        do_frame(10'h1A5, d_off, b_off, sl, ms);
        do_frame(10'h222, d_off, b_off, sl, ms);
        do_frame(10'h300, d_off, b_off, sl, ms);
        check("a5_done_off", d_off, 23);
        check("a5_ss_low", sl, 23);
        check("a5_rx_data", rx_data, 8'hA5);
        do_frame(10'h155, d_off, b_off, sl, ms);
        check("a5_hold_rx_data", rx_data, 8'hA5);

        // start pulses at E5 and E12 must be ignored
        dn0 = done_cnt;
        hi_ok = 0;
        start = 1'b1;
        cmd = 10'h0AB;
        @(posedge clk);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            start = (n == 4 || n == 11);
            cmd = FW'($urandom);
            if (n >= 12 && n <= 14 && SS_n) hi_ok++;
        end
        start = 1'b0;
        check("ign_done_cnt", done_cnt - dn0, 1);
        check("ign_gap_high", hi_ok, 3);
        check("ign_idle", busy, 0);

        // start held high: the gap between frames is set by busy dropping
        start = 1'b1;
        cmd = 10'h3FF;
        prev_ss = 1'b1;
        hi_run = 0;
        runs = 0;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            cmd = FW'($urandom);
            if (SS_n) hi_run++;
            else begin
                if (prev_ss && n > 0) begin
                    check("held_gap_len", hi_run, GAP + 1);
                    runs++;
                end
                hi_run = 0;
            end
            prev_ss = SS_n;
        end
        start = 1'b0;
        check("held_frames_seen", runs >= 3, 1);
        for (int n = 0; n < 40 && busy; n++) @(negedge clk);
        check("held_drain", busy, 0);

        for (int i = 0; i < 30; i++) begin
            logic [FW-1:0] c;
            c = FW'($urandom);
            do_frame(c, d_off, b_off, sl, ms);
            check("rand_done_off", d_off, (c[9:8] == 2'b11) ? L_RD : L_WR);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // reset in the middle of SHIFT abandons the frame
        dn0 = done_cnt;
        start = 1'b1;
        cmd = 10'h001;
        @(posedge clk);
        repeat (5) @(negedge clk);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ss_n", SS_n, 1);
        check("mid_rst_mosi", MOSI, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("mid_rst_no_done", done_cnt - dn0, 0);
        check("mid_rst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
